torpedo_scheduler: RTL and testbench

- Allocates the T_NUM torpedo instances (slots) to fire-button presses.
- Replaces the current cascaded fire chain.
- Edge-detects the fire button, enforces an inter-shot cooldown and picks a free slot round-robin.
- Issues a one-cycle launch pulse to that slot, then retires the slot on hit or when its time-to-live expires.
- Sits in the game top level between periphery_control (fire button), the collision logic and the torpedo unit instances.

---
 rtl/torpedo_pkg.sv | 12 +
 rtl/torpedo_slot_timer.sv | 38 +++
 rtl/torpedo_scheduler.sv | 112 +++++++++++
 tb/tb_torpedo_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/torpedo_pkg.sv
// Shared types and width helpers for the torpedo slot scheduler.
package torpedo_pkg;

    typedef enum logic [1:0] {S_IDLE, S_WAIT_CD, S_LAUNCH} tsched_state_t;

    localparam int unsigned TTL_W = 6;

    function automatic int unsigned slot_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/torpedo_slot_timer.sv
// One torpedo slot: in-flight flag plus remaining-lifetime counter in frames.
module torpedo_slot_timer
    import torpedo_pkg::*;
#(
    parameter int unsigned TTL_FRAMES = 60
) (
    input  logic             clk_25,
    input  logic             resetN,
    input  logic             load,
    input  logic             hit,
    input  logic             frame_pulse,
    input  logic             abort,
    output logic             active,
    output logic [TTL_W-1:0] ttl
);

    // load wins over hit/frame_pulse: the slot was inactive when it was picked
    always_ff @(posedge clk_25 or negedge resetN) begin
        if (!resetN) begin
            active <= 1'b0;
            ttl    <= '0;
        end else if (abort) begin
            active <= 1'b0;
            ttl    <= '0;
        end else if (load) begin
            active <= 1'b1;
            ttl    <= TTL_W'(TTL_FRAMES);
        end else if (active) begin
            if (hit || (frame_pulse && ttl == TTL_W'(1))) begin
                active <= 1'b0;
                ttl    <= '0;
            end else if (frame_pulse) begin
                ttl <= ttl - 1'b1;
            end
        end
    end

endmodule

// File: rtl/torpedo_scheduler.sv
// Maps fire-button presses onto free torpedo slots with cooldown and round-robin choice.
module torpedo_scheduler
    import torpedo_pkg::*;
#(
    parameter int unsigned T_NUM           = 4,
    parameter int unsigned TTL_FRAMES      = 60,
    parameter int unsigned COOLDOWN_FRAMES = 8
) (
    input  logic                   clk_25,
    input  logic                   resetN,
    input  logic                   frame_pulse,
    input  logic                   game_active,
    input  logic                   fire_btn,
    input  logic [T_NUM-1:0]       hit,
    output logic [T_NUM-1:0]       launch,
    output logic [T_NUM-1:0]       active,
    output logic [T_NUM*TTL_W-1:0] ttl_remaining,
    output logic                   fire_dropped
);

    localparam int unsigned IDX_W = slot_idx_w(T_NUM);
    localparam int unsigned CD_W  = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

    tsched_state_t    state, state_next;
    logic [CD_W-1:0]  cooldown, cooldown_next;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] free_idx;
    logic             free_found;
    logic             fire_d;
    logic             press;
    logic             abort;

    assign press = fire_btn & ~fire_d;
    assign abort = ~game_active;

    always_comb begin
        int unsigned cand;
        free_found = 1'b0;
        free_idx   = '0;
        cand       = 0;
        for (int unsigned i = 0; i < T_NUM; i++) begin
            cand = 32'(rr_ptr) + i;
            if (cand >= T_NUM) cand = cand - T_NUM;
            if (!free_found && !active[IDX_W'(cand)]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        launch       = '0;
        fire_dropped = 1'b0;
        if (state == S_LAUNCH && game_active) begin
            if (free_found) launch[free_idx] = 1'b1;
            else            fire_dropped     = 1'b1;
        end
    end

    always_comb begin
        if (!game_active)                          cooldown_next = '0;
        else if (|launch)                          cooldown_next = CD_W'(COOLDOWN_FRAMES);
        else if (frame_pulse && cooldown != '0)    cooldown_next = cooldown - 1'b1;
        else                                       cooldown_next = cooldown;
    end

    // Waiting releases on the frame that empties the cooldown, so launch lands one cycle after it
    always_comb begin
        state_next = state;
        if (!game_active) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (press) state_next = (cooldown == '0) ? S_LAUNCH : S_WAIT_CD;
                S_WAIT_CD: if (cooldown_next == '0) state_next = S_LAUNCH;
                S_LAUNCH:  state_next = S_IDLE;
                default:   state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_25 or negedge resetN) begin
        if (!resetN) begin
            state    <= S_IDLE;
            cooldown <= '0;
            rr_ptr   <= '0;
            fire_d   <= 1'b0;
        end else begin
            state    <= state_next;
            cooldown <= cooldown_next;
            fire_d   <= fire_btn;
            if (|launch)
                rr_ptr <= (free_idx == IDX_W'(T_NUM - 1)) ? '0 : free_idx + 1'b1;
        end
    end

    for (genvar g = 0; g < T_NUM; g++) begin : g_slot
        torpedo_slot_timer #(
            .TTL_FRAMES(TTL_FRAMES)
        ) u_timer (
            .clk_25     (clk_25),
            .resetN     (resetN),
            .load       (launch[g]),
            .hit        (hit[g]),
            .frame_pulse(frame_pulse),
            .abort      (abort),
            .active     (active[g]),
            .ttl        (ttl_remaining[g*TTL_W +: TTL_W])
        );
    end

endmodule

// File: tb/tb_torpedo_scheduler.sv
// Bench for torpedo_scheduler: directed scenarios plus random traffic against a behavioural model.
module tb_torpedo_scheduler;

    localparam int T   = 4;
    localparam int TTL = 60;
    localparam int CD  = 8;
    localparam int FL  = 16;

    logic           clk_25 = 1'b0;
    logic           resetN;
    logic           frame_pulse;
    logic           game_active;
    logic           fire_btn;
    logic [T-1:0]   hit;
    logic [T-1:0]   launch;
    logic [T-1:0]   active;
    logic [T*6-1:0] ttl_remaining;
    logic           fire_dropped;

    always #5 clk_25 = ~clk_25;

    torpedo_scheduler #(
        .T_NUM          (T),
        .TTL_FRAMES     (TTL),
        .COOLDOWN_FRAMES(CD)
    ) dut (
        .clk_25       (clk_25),
        .resetN       (resetN),
        .frame_pulse  (frame_pulse),
        .game_active  (game_active),
        .fire_btn     (fire_btn),
        .hit          (hit),
        .launch       (launch),
        .active       (active),
        .ttl_remaining(ttl_remaining),
        .fire_dropped (fire_dropped)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int frames_total = 0;

    // behavioural model: slot table, cooldown, pointer, pending request
    bit m_act[T];
    int m_ttl[T];
    int m_cd, m_rr;
    bit m_fd, m_go, m_wait;

    logic [T-1:0]   s_launch, s_active;
    logic [T*6-1:0] s_ttl;
    logic           s_drop, s_fp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    task automatic model_clear();
        for (int i = 0; i < T; i++) begin
            m_act[i] = 1'b0;
            m_ttl[i] = 0;
        end
        m_cd = 0; m_rr = 0; m_fd = 1'b0; m_go = 1'b0; m_wait = 1'b0;
    endtask

    task automatic step(input bit fp, input bit ga, input bit fb, input logic [T-1:0] h);
        int e_k, cd_old, cd_after;
        bit e_drop, press, nx_go, nx_wait;
        logic [T-1:0] e_launch, e_act;
        logic [T*6-1:0] e_ttl;
        @(negedge clk_25);
        frame_pulse = fp; game_active = ga; fire_btn = fb; hit = h;
        #2;
        e_k = -1; e_drop = 1'b0;
        if (m_go && ga) begin
            for (int i = 0; i < T; i++) begin
                int c;
                c = (m_rr + i) % T;
                if (e_k < 0 && !m_act[c]) e_k = c;
            end
            if (e_k < 0) e_drop = 1'b1;
        end
        e_launch = '0;
        if (e_k >= 0) e_launch[e_k] = 1'b1;
        for (int i = 0; i < T; i++) begin
            e_act[i]       = m_act[i];
            e_ttl[i*6 +: 6] = 6'(m_ttl[i]);
        end
        chk("launch", 32'(launch), 32'(e_launch));
        chk("dropped", 32'(fire_dropped), 32'(e_drop));
        chk("active", 32'(active), 32'(e_act));
        chk("ttl", 32'(ttl_remaining), 32'(e_ttl));
        s_launch = launch; s_active = active; s_ttl = ttl_remaining; s_drop = fire_dropped; s_fp = fp;
        @(posedge clk_25);
        if (!ga) begin
            for (int i = 0; i < T; i++) begin
                m_act[i] = 1'b0;
                m_ttl[i] = 0;
            end
            m_cd = 0; m_go = 1'b0; m_wait = 1'b0;
        end else begin
            for (int i = 0; i < T; i++) begin
                if (e_k == i) begin
                    m_act[i] = 1'b1;
                    m_ttl[i] = TTL;
                end else if (m_act[i]) begin
                    if (h[i]) begin
                        m_act[i] = 1'b0;
                        m_ttl[i] = 0;
                    end else if (fp) begin
                        m_ttl[i]--;
                        if (m_ttl[i] == 0) m_act[i] = 1'b0;
                    end
                end
            end
            cd_old = m_cd;
            if (e_k >= 0) cd_after = CD;
            else if (fp && m_cd > 0) cd_after = m_cd - 1;
            else cd_after = m_cd;
            press   = fb && !m_fd;
            nx_go   = (!m_go && !m_wait && press && cd_old == 0) || (m_wait && cd_after == 0);
            nx_wait = (!m_go && !m_wait && press && cd_old > 0) || (m_wait && cd_after > 0);
            if (e_k >= 0) m_rr = (e_k + 1) % T;
            m_cd = cd_after; m_go = nx_go; m_wait = nx_wait;
        end
        m_fd = fb;
        if (fp) frames_total++;
        cyc++;
    endtask

    task automatic tick(input bit fb, input bit ga = 1'b1, input logic [T-1:0] h = '0);
        step((cyc % FL) == FL - 1, ga, fb, h);
    endtask

    task automatic do_reset();
        @(posedge clk_25);
        #3;
        resetN = 1'b0;
        frame_pulse = 1'b0; fire_btn = 1'b0; hit = '0; game_active = 1'b1;
        #1;
        chk("rst_launch", 32'(launch), 32'd0);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_ttl", 32'(ttl_remaining), 32'd0);
        chk("rst_dropped", 32'(fire_dropped), 32'd0);
        model_clear();
        repeat (2) @(posedge clk_25);
        @(negedge clk_25);
        resetN = 1'b1;
        cyc = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_l, f0, fb_before, guard;
        bit pf, got, rb;
        logic [T-1:0] rh;
        resetN = 1'b1; frame_pulse = 1'b0; game_active = 1'b1; fire_btn = 1'b0; hit = '0;

        // single press held for 500 cycles
        do_reset();
        repeat (10) tick(1'b0);
        tick(1'b1);
        tick(1'b1);
        chk("t1_launch", 32'(s_launch), 32'b0001);
        tick(1'b1);
        chk("t1_active0", 32'(s_active[0]), 32'd1);
        n_l = 0;
        repeat (497) begin
            tick(1'b1);
            if (s_launch != '0) n_l++;
        end
        chk("t1_no_relaunch", n_l, 0);

        // second press inside cooldown
        do_reset();
        repeat (10) tick(1'b0);
        tick(1'b1);
        tick(1'b0);
        chk("t2_first", 32'(s_launch), 32'b0001);
        f0 = frames_total;
        guard = 0;
        while (frames_total - f0 < 2 && guard < 100) begin
            tick(1'b0);
            guard++;
        end
        tick(1'b1);
        got = 1'b0; fb_before = 0; pf = 1'b0;
        for (int g = 0; g < 400; g++) begin
            fb_before = frames_total;
            pf = s_fp;
            tick(1'b0);
            if (s_launch != '0) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) timeout("t2_wait_launch");
        else begin
            chk("t2_second", 32'(s_launch), 32'b0010);
            chk("t2_frames", fb_before - f0, 8);
            chk("t2_prev_fp", 32'(pf), 32'd1);
        end

        // round robin until full, then expiry and wrap
        do_reset();
        f0 = 0;
        for (int p = 0; p < 5; p++) begin
            while (cyc < 10 + p * 160) tick(1'b0);
            tick(1'b1);
            tick(1'b0);
            chk("t3_launch", 32'(s_launch), (p < 4) ? (32'd1 << p) : 32'd0);
            chk("t3_dropped", 32'(s_drop), (p == 4) ? 32'd1 : 32'd0);
            if (p == 0) f0 = frames_total;
        end
        got = 1'b0;
        for (int g = 0; g < 1200; g++) begin
            fb_before = frames_total;
            tick(1'b0);
            if (!s_active[0]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) timeout("t4_wait_expiry");
        else chk("t4_expiry_frames", fb_before - f0, 60);
        tick(1'b1);
        tick(1'b0);
        chk("t4_wrap_launch", 32'(s_launch), 32'b0001);

        // hit and frame pulse together on a slot with one frame left
        got = 1'b0;
        for (int g = 0; g < 1000; g++) begin
            tick(1'b0);
            if (m_act[1] && m_ttl[1] == 1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) timeout("t5_wait_ttl1");
        else begin
            step(1'b1, 1'b1, 1'b0, 4'b0010);
            chk("t5_pre_ttl1", 32'(s_ttl[6 +: 6]), 32'd1);
            chk("t5_pre_ttl2", 32'(s_ttl[12 +: 6]), 32'd11);
            chk("t5_pre_ttl3", 32'(s_ttl[18 +: 6]), 32'd21);
            tick(1'b0);
            chk("t5_active1", 32'(s_active[1]), 32'd0);
            chk("t5_ttl1", 32'(s_ttl[6 +: 6]), 32'd0);
            chk("t5_ttl2", 32'(s_ttl[12 +: 6]), 32'd10);
            chk("t5_ttl3", 32'(s_ttl[18 +: 6]), 32'd20);
        end

        // abort while waiting on cooldown with three slots in flight
        do_reset();
        for (int p = 0; p < 3; p++) begin
            while (cyc < 10 + p * 160) tick(1'b0);
            tick(1'b1);
            tick(1'b0);
        end
        while (cyc < 340) tick(1'b0);
        tick(1'b1);
        repeat (4) tick(1'b0);
        chk("t6_three_active", 32'(s_active), 32'b0111);
        tick(1'b0, 1'b0);
        tick(1'b0);
        chk("t6_active_cleared", 32'(s_active), 32'd0);
        chk("t6_ttl_cleared", 32'(s_ttl), 32'd0);
        n_l = 0;
        repeat (320) begin
            tick(1'b0);
            if (s_launch != '0) n_l++;
        end
        chk("t6_no_launch", n_l, 0);
        tick(1'b1);
        tick(1'b0);
        chk("t6_rr_kept", 32'(s_launch), 32'b1000);

        // reset asserted mid-flight with a request pending
        tick(1'b0);
        tick(1'b1);
        repeat (3) tick(1'b0);
        do_reset();
        n_l = 0;
        repeat (400) begin
            tick(1'b0);
            if (s_launch != '0 || s_drop) n_l++;
        end
        chk("t7_no_launch_after_reset", n_l, 0);

        // random traffic
        do_reset();
        rb = 1'b0;
        repeat (4000) begin
            if ($urandom % 5 == 0) rb = ~rb;
            for (int i = 0; i < T; i++) rh[i] = ($urandom % 30 == 0);
            step(($urandom % 8) == 0, ($urandom % 300) != 0, rb, rh);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
